// File: rtl/weight_bram_sequencer.sv
// Sequences load and read sweeps over one per-neuron weight BRAM through its single negedge-clocked port.
// Latency: a read issued in cycle t returns W_DATA/W_INDEX in cycle t+1; a load handshake in cycle t writes in cycle t+1.
// Backpressure: ld_ready stalls the host stream; hold stalls read issue without dropping in-flight words.
module weight_bram_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          rd_start,
    input  logic          hold,
    output logic          w_valid,
    output logic [DW-1:0] w_data,
    output logic [AW-1:0] w_index,
    output logic          w_last,
    output logic          ld_done,
    output logic          busy,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_di,
    output logic          bram_en,
    output logic          bram_we,
    input  logic [DW-1:0] bram_do
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic          rd_pend;
    logic          ld_pend;
    // Set once address DEPTH-1 has been issued; the following cycle closes the read sweep.
    logic          rd_tail;
    logic          ld_hs;

    // Counter wraps only at the last valid address, so addresses >= DEPTH never reach the port.
    function automatic logic [AW-1:0] cnt_inc(input logic [AW-1:0] c);
        return (c == LAST_ADDR) ? '0 : c + 1'b1;
    endfunction

    assign ld_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign ld_hs    = ld_valid & ld_ready;

    // Sweep FSM: owns the BRAM port, the sweep counter and the one-deep pending flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_pend   <= 1'b0;
            ld_pend   <= 1'b0;
            rd_tail   <= 1'b0;
            ld_done   <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_di   <= '0;
        end else begin
            bram_en <= 1'b0;
            bram_we <= 1'b0;
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    ld_pend <= 1'b0;
                    rd_tail <= 1'b0;
                    if (ld_start) begin
                        // Load wins a tie; the read is remembered and runs right after.
                        state   <= LOAD;
                        cnt     <= '0;
                        rd_pend <= rd_start;
                    end else if (rd_start) begin
                        state   <= READ;
                        rd_pend <= 1'b0;
                        if (!hold) begin
                            // First read goes straight out so address 0 is on the port next cycle.
                            bram_en   <= 1'b1;
                            bram_addr <= '0;
                            cnt       <= cnt_inc('0);
                            rd_tail   <= (LAST_ADDR == '0);
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (rd_start) begin
                        rd_pend <= 1'b1;
                    end
                    if (ld_hs) begin
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= cnt;
                        bram_di   <= ld_data;
                        cnt       <= cnt_inc(cnt);
                        if (cnt == LAST_ADDR) begin
                            ld_done <= 1'b1;
                            if (rd_pend || rd_start) begin
                                state   <= READ;
                                rd_pend <= 1'b0;
                                rd_tail <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                READ: begin
                    if (ld_start) begin
                        ld_pend <= 1'b1;
                    end
                    if (rd_tail) begin
                        // Port is left idle this cycle; the last word is being captured.
                        rd_tail <= 1'b0;
                        ld_pend <= 1'b0;
                        state   <= (ld_pend || ld_start) ? LOAD : IDLE;
                    end else if (!hold) begin
                        bram_en   <= 1'b1;
                        bram_addr <= cnt;
                        cnt       <= cnt_inc(cnt);
                        if (cnt == LAST_ADDR) begin
                            rd_tail <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture: every read on the port in cycle t is delivered exactly once in cycle t+1, regardless of hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid <= 1'b0;
            w_data  <= '0;
            w_index <= '0;
            w_last  <= 1'b0;
        end else begin
            w_valid <= bram_en & ~bram_we;
            w_last  <= bram_en & ~bram_we & (bram_addr == LAST_ADDR);
            if (bram_en && !bram_we) begin
                w_data  <= bram_do;
                w_index <= bram_addr;
            end
        end
    end

endmodule

// File: tb/tb_weight_bram_sequencer.sv
module tb_weight_bram_sequencer;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_start, ld_valid, ld_ready, rd_start, hold;
    logic [DW-1:0] ld_data;
    logic          w_valid, w_last, ld_done, busy, bram_en, bram_we;
    logic [DW-1:0] w_data, bram_di;
    logic [DW-1:0] bram_do = '0;
    logic [AW-1:0] w_index, bram_addr;

    int checks = 0;
    int errors = 0;

    // Observation counters, written only by the monitor.
    int n_words = 0, n_last = 0, n_writes = 0, n_done = 0, n_busy_low = 0, mcyc = 0;
    int last_done_cyc = -1, last_rd0_cyc = -1, last_wlast_cyc = -1, ld_enter_cyc = -1;
    logic [DW-1:0] golden   [DEPTH];
    logic [DW-1:0] ld_words [DEPTH];
    logic [DW-1:0] mem      [DEPTH];
    bit            mem_init = 1'b0;

    weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .rd_start(rd_start), .hold(hold),
        .w_valid(w_valid), .w_data(w_data), .w_index(w_index), .w_last(w_last),
        .ld_done(ld_done), .busy(busy),
        .bram_addr(bram_addr), .bram_di(bram_di), .bram_en(bram_en), .bram_we(bram_we),
        .bram_do(bram_do)
    );

    always #5 clk = ~clk;

    // Negedge-clocked single-port BRAM, preloaded with w[i] = i + 100.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(100 + i);
            mem_init <= 1'b1;
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_di;
            else         bram_do <= mem[bram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_w_valid"}, w_valid, 0);
        chk({pfx, "_w_data"}, w_data, 0);
        chk({pfx, "_w_index"}, w_index, 0);
        chk({pfx, "_w_last"}, w_last, 0);
        chk({pfx, "_ld_done"}, ld_done, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_ld_ready"}, ld_ready, 0);
        chk({pfx, "_bram_en"}, bram_en, 0);
        chk({pfx, "_bram_we"}, bram_we, 0);
        chk({pfx, "_bram_addr"}, bram_addr, 0);
        chk({pfx, "_bram_di"}, bram_di, 0);
    endtask

    // Reference model: expected memory contents, load order and read order, checked once per cycle.
    task automatic monitor();
        logic pv = 1'b0;
        logic p_en = 0, p_we = 0, p_ready = 0, p_valid = 0, p_busy = 0, p_hold = 0, p_lds = 0, p_rds = 0;
        logic [DW-1:0] p_data = '0;
        int exp_wr = 0, exp_rd = 0;
        for (int i = 0; i < DEPTH; i++) golden[i] = DW'(100 + i);
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst_n) begin
                pv = 1'b0;
                exp_wr = 0;
                exp_rd = 0;
            end else begin
                if (pv) begin
                    chk("w_valid_rule", w_valid, p_en & ~p_we);
                    if (w_valid) begin
                        chk("rd_index", w_index, exp_rd);
                        chk("rd_data", w_data, golden[exp_rd]);
                        chk("rd_last", w_last, exp_rd == DEPTH - 1);
                        n_words++;
                        if (w_last) begin
                            n_last++;
                            last_wlast_cyc = mcyc;
                        end
                        exp_rd = (exp_rd + 1) % DEPTH;
                    end else begin
                        chk("w_last_idle", w_last, 0);
                    end
                    if (p_ready) begin
                        if (p_valid) begin
                            chk("wr_en", bram_en, 1);
                            chk("wr_we", bram_we, 1);
                            chk("wr_addr", bram_addr, exp_wr);
                            chk("wr_di", bram_di, p_data);
                            chk("ld_done_hs", ld_done, exp_wr == DEPTH - 1);
                            golden[exp_wr] = p_data;
                            exp_wr = (exp_wr + 1) % DEPTH;
                            n_writes++;
                        end else begin
                            chk("wr_idle_en", bram_en, 0);
                            chk("ld_done_idle", ld_done, 0);
                        end
                    end else begin
                        chk("ld_done_noload", ld_done, 0);
                        if (p_busy && p_hold) chk("hold_blocks_issue", bram_en, 0);
                        if (!p_busy) begin
                            chk("idle_busy", busy, p_lds | p_rds);
                            chk("idle_issue", bram_en, p_rds & ~p_lds & ~p_hold);
                        end
                    end
                    if (bram_en) chk("addr_range", bram_addr < DEPTH, 1);
                    if (bram_we) chk("we_needs_en", bram_en, 1);
                    if (ld_done) begin
                        n_done++;
                        last_done_cyc = mcyc;
                    end
                    if (bram_en && !bram_we && bram_addr == 0) last_rd0_cyc = mcyc;
                    if (!busy) n_busy_low++;
                    if (ld_ready && !p_ready) ld_enter_cyc = mcyc;
                end
                p_en = bram_en; p_we = bram_we; p_ready = ld_ready; p_valid = ld_valid;
                p_busy = busy; p_hold = hold; p_lds = ld_start; p_rds = rd_start; p_data = ld_data;
                pv = 1'b1;
            end
        end
    endtask

    // Streams ld_words; mode 0 = always valid, 1 = valid every other cycle, 2 = random valid.
    task automatic load_words(input bit pulse, input int mode);
        int i = 0, cyc = 0;
        if (pulse) begin
            ld_start = 1'b1;
            tick();
            ld_start = 1'b0;
        end
        while (i < DEPTH && cyc < 600) begin
            ld_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
            ld_data  = ld_words[i];
            @(negedge clk);
            if (ld_valid && ld_ready) i++;
            tick();
            cyc++;
        end
        ld_valid = 1'b0;
        chk("ld_timeout", i, DEPTH);
    endtask

    task automatic read_sweep(input bit pulse, input int hold_pct);
        int l0 = n_last, w0 = n_words, guard = 0;
        if (pulse) begin
            rd_start = 1'b1;
            hold = 1'b0;
            tick();
            rd_start = 1'b0;
        end
        while (n_last == l0 && guard < 600) begin
            hold = ($urandom_range(99) < hold_pct);
            tick();
            guard++;
        end
        hold = 1'b0;
        chk("rd_timeout", guard < 600, 1);
        chk("rd_words", n_words - w0, DEPTH);
    endtask

    initial begin
        int w0, l0, d0, wr0, b0, guard, hs;
        rst_n = 1'b0; ld_start = 0; ld_valid = 0; ld_data = '0; rd_start = 0; hold = 0;
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // Test 1: exact timing of a read sweep over the preloaded BRAM.
        rd_start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            rd_start = 1'b0;
            @(negedge clk);
            chk("t1_en", bram_en, k <= DEPTH);
            if (k <= DEPTH) begin
                chk("t1_addr", bram_addr, k - 1);
                chk("t1_we", bram_we, 0);
            end
            chk("t1_valid", w_valid, (k >= 2 && k <= DEPTH + 1));
            if (k >= 2 && k <= DEPTH + 1) chk("t1_data", w_data, 100 + k - 2);
            chk("t1_last", w_last, k == DEPTH + 1);
        end
        tick();

        // Test 2: load 0xA000+i with valid toggling, then read it back.
        for (int i = 0; i < DEPTH; i++) ld_words[i] = DW'(16'hA000 + i);
        wr0 = n_writes; d0 = n_done;
        load_words(1'b1, 1);
        tick();
        chk("t2_writes", n_writes - wr0, DEPTH);
        chk("t2_done", n_done - d0, 1);
        chk("t2_golden_last", golden[DEPTH-1], 16'hA01B);
        read_sweep(1'b1, 0);

        // Test 3: hold for 3 cycles right after word 5 is issued.
        w0 = n_words; l0 = n_last;
        rd_start = 1'b1;
        hold = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            rd_start = 1'b0;
            hold = (k >= 6 && k <= 8);
            @(negedge clk);
            if (k >= 2 && k <= 7) begin
                chk("t3_valid", w_valid, 1);
                chk("t3_index", w_index, k - 2);
            end else if (k >= 8 && k <= 10) begin
                chk("t3_gap", w_valid, 0);
            end else if (k >= 11) begin
                chk("t3_valid", w_valid, 1);
                chk("t3_index", w_index, k - 5);
            end
        end
        tick();
        hold = 1'b0;
        guard = 0;
        while (n_last == l0 && guard < 200) begin
            tick();
            guard++;
        end
        chk("t3_timeout", guard < 200, 1);
        chk("t3_words", n_words - w0, DEPTH);

        // Test 4: simultaneous starts; load first, read the cycle after ld_done, busy held.
        for (int i = 0; i < DEPTH; i++) ld_words[i] = DW'($urandom);
        ld_start = 1'b1;
        rd_start = 1'b1;
        tick();
        ld_start = 1'b0;
        rd_start = 1'b0;
        b0 = n_busy_low; d0 = n_done;
        load_words(1'b0, 2);
        read_sweep(1'b0, 0);
        chk("t4_done", n_done - d0, 1);
        chk("t4_read_after_done", last_rd0_cyc, last_done_cyc + 1);
        // Busy only drops in the cycle that delivers the last word.
        chk("t4_busy_low", n_busy_low - b0, 1);

        // Test 5: asynchronous reset mid-load at cnt=10, then a fresh load from address 0.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        hs = 0; guard = 0;
        while (hs < 10 && guard < 100) begin
            ld_data = DW'($urandom);
            @(negedge clk);
            if (ld_ready) hs++;
            tick();
            guard++;
        end
        ld_valid = 1'b0;
        chk("t5_pre_en", bram_en, 1);
        chk("t5_pre_addr", bram_addr, 9);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("t5_async");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) ld_words[i] = DW'($urandom);
        wr0 = n_writes;
        load_words(1'b1, 2);
        tick();
        chk("t5_writes", n_writes - wr0, DEPTH);
        read_sweep(1'b1, 20);

        // Test 6: repeated rd_start during READ is ignored; ld_start queues a load after the sweep.
        w0 = n_words; l0 = n_last;
        rd_start = 1'b1;
        hold = 1'b0;
        tick();
        rd_start = 1'b0;
        guard = 0;
        while (n_last == l0 && guard < 400) begin
            tick();
            guard++;
            rd_start = (guard == 5 || guard == 9 || guard == 13);
            ld_start = (guard == 7);
            hold = ($urandom_range(99) < 30);
        end
        rd_start = 1'b0; ld_start = 1'b0; hold = 1'b0;
        chk("t6_timeout", guard < 400, 1);
        chk("t6_words", n_words - w0, DEPTH);
        chk("t6_load_after_last", ld_enter_cyc, last_wlast_cyc);
        for (int i = 0; i < DEPTH; i++) ld_words[i] = DW'($urandom);
        load_words(1'b0, 0);
        repeat (40) tick();
        chk("t6_one_sweep", n_last - l0, 1);
        chk("t6_idle", busy, 0);
        read_sweep(1'b1, 30);

        // Randomized load/read rounds against the model.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) ld_words[i] = DW'($urandom);
            load_words(1'b1, 2);
            read_sweep(1'b1, 25);
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
